// File: rtl/bcd_pkg.sv
// Shared BCD constants and the limit-clamp helper for the cascaded up/down counter.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;
    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Limit codes 10..15 are not BCD; they behave as 9.
    function automatic logic [BCD_W-1:0] clamp_limit(input logic [BCD_W-1:0] lim);
        return (lim > BCD_NINE) ? BCD_NINE : lim;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter: holds its value, steps when step_in is high and
// reports a wrap to the next digit.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_in,
    input  logic             up,
    input  logic [BCD_W-1:0] limit,
    input  logic             load,
    input  logic [BCD_W-1:0] init,
    output logic [BCD_W-1:0] value,
    output logic             wrap_out
);

    logic [BCD_W-1:0] lim_c;
    logic [BCD_W-1:0] next_value;
    logic             at_edge;

    // Non-BCD stored digits (above 9) still satisfy ">= limit", so they wrap to 0 going up.
    always_comb begin
        lim_c      = clamp_limit(limit);
        next_value = value;
        at_edge    = 1'b0;
        if (dir_e'(up) == DIR_UP) begin
            at_edge    = (value >= lim_c);
            next_value = at_edge ? BCD_ZERO : value + 4'd1;
        end else begin
            at_edge    = (value == BCD_ZERO);
            next_value = at_edge ? lim_c : value - 4'd1;
        end
    end

    assign wrap_out = step_in & at_edge;

    // NOTE: reset reloads init rather than zero, so the reset value follows init_value at that edge.
    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            value <= init;
        end else if (step_in) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded NUM_DIGITS BCD up/down counter with per-digit limits and a wrap pulse.
// Optional auto-stop at zero when counting down: define BCD_COUNTER_AUTOSTOP_EN.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        tick,
    input  logic                        up,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] init_value,
    input  logic [BCD_W*NUM_DIGITS-1:0] limit,
    output logic [BCD_W*NUM_DIGITS-1:0] value,
    output logic                        wrap,
    output logic                        is_zero,
    output logic                        done
);

    logic [NUM_DIGITS:0] carry;
    logic                step;
    logic                step_en;
    logic                done_q;

    assign step    = en & tick & ~load;
    assign is_zero = (value == '0);

`ifdef BCD_COUNTER_AUTOSTOP_EN
    logic stop_hit;

    // A down step from all-zero parks the counter instead of wrapping.
    assign stop_hit = step & ~done_q & ~up & is_zero;
    assign step_en  = step & ~done_q & ~stop_hit;

    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            done_q <= 1'b0;
        end else if (stop_hit) begin
            done_q <= 1'b1;
        end
    end
`else
    assign step_en = step;
    assign done_q  = 1'b0;
`endif

    assign done     = done_q;
    assign carry[0] = step_en;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .step_in  (carry[i]),
            .up       (up),
            .limit    (limit[i*BCD_W +: BCD_W]),
            .load     (load),
            .init     (init_value[i*BCD_W +: BCD_W]),
            .value    (value[i*BCD_W +: BCD_W]),
            .wrap_out (carry[i+1])
        );
    end

    // Carry out of the top digit means every digit wrapped on this step.
    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= carry[NUM_DIGITS];
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter: directed vector table, hand sequences
// and randomized stimulus against a mixed-radix arithmetic reference model.
module tb_bcd_updown_counter;

    localparam int ND = 4;
    localparam int W  = 4 * ND;
`ifdef BCD_COUNTER_AUTOSTOP_EN
    localparam bit AUTOSTOP = 1'b1;
`else
    localparam bit AUTOSTOP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, en, tick, up, load;
    logic [W-1:0] init_value, limit, value;
    logic         wrap, is_zero, done;

    int tests_run = 0;
    int tests_failed = 0;

    bcd_updown_counter #(.NUM_DIGITS(ND)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .tick       (tick),
        .up         (up),
        .load       (load),
        .init_value (init_value),
        .limit      (limit),
        .value      (value),
        .wrap       (wrap),
        .is_zero    (is_zero),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           load;
        bit           en;
        bit           tick;
        bit           up;
        logic [W-1:0] init;
        logic [W-1:0] limit;
        logic [W-1:0] exp_val;
        bit           exp_wrap;
        bit           exp_done;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit ld, input bit e, input bit t, input bit u,
                         input logic [W-1:0] iv, input logic [W-1:0] lm);
        rst_n = r; load = ld; en = e; tick = t; up = u; init_value = iv; limit = lm;
    endtask

    task automatic edge_check(input string name, input logic [W-1:0] ev, input bit ew, input bit ed);
        @(posedge clk);
        #1;
        check({name, " value"}, 32'(value), 32'(ev));
        check({name, " wrap"}, 32'(wrap), 32'(ew));
        check({name, " done"}, 32'(done), 32'(ed));
        check({name, " is_zero"}, 32'(is_zero), 32'(ev == '0));
    endtask

    // Reference model: the counter is a mixed-radix number with radix (clamped limit + 1) per digit.
    function automatic int radix_of(input logic [W-1:0] lm, input int i);
        int d;
        d = int'(lm[i*4 +: 4]);
        return ((d > 9) ? 9 : d) + 1;
    endfunction

    function automatic int to_int(input logic [W-1:0] v, input logic [W-1:0] lm);
        int n = 0;
        int w = 1;
        for (int i = 0; i < ND; i++) begin
            n += int'(v[i*4 +: 4]) * w;
            w *= radix_of(lm, i);
        end
        return n;
    endfunction

    function automatic int total_of(input logic [W-1:0] lm);
        int t = 1;
        for (int i = 0; i < ND; i++) t *= radix_of(lm, i);
        return t;
    endfunction

    function automatic logic [W-1:0] from_int(input int n, input logic [W-1:0] lm);
        logic [W-1:0] v = '0;
        int           r;
        for (int i = 0; i < ND; i++) begin
            r = radix_of(lm, i);
            v[i*4 +: 4] = 4'(n % r);
            n = n / r;
        end
        return v;
    endfunction

    logic [W-1:0] m_val;
    bit           m_wrap, m_done;

    task automatic model_edge();
        int n, tot;
        if (!rst_n || load) begin
            m_val = init_value; m_wrap = 0; m_done = 0;
        end else begin
            m_wrap = 0;
            if (en && tick && !m_done) begin
                n   = to_int(m_val, limit);
                tot = total_of(limit);
                if (up) begin
                    n++;
                    if (n == tot) begin n = 0; m_wrap = 1; end
                end else if (n == 0) begin
                    if (AUTOSTOP) m_done = 1;
                    else begin n = tot - 1; m_wrap = 1; end
                end else begin
                    n--;
                end
                m_val = from_int(n, limit);
            end
        end
    endtask

    function automatic logic [W-1:0] rand_valid(input logic [W-1:0] lm);
        logic [W-1:0] v;
        for (int i = 0; i < ND; i++) v[i*4 +: 4] = 4'($urandom_range(0, radix_of(lm, i) - 1));
        return v;
    endfunction

    initial begin
        // Directed vectors, applied back to back; each row is one clock edge.
        vecs[0]  = '{1, 1, 1, 1, 16'h0059, 16'h5959, 16'h0059, 0, 0};
        vecs[1]  = '{0, 1, 1, 1, 16'h0000, 16'h5959, 16'h0100, 0, 0};
        vecs[2]  = '{1, 0, 0, 1, 16'h5959, 16'h5959, 16'h5959, 0, 0};
        vecs[3]  = '{0, 1, 1, 1, 16'h0000, 16'h5959, 16'h0000, 1, 0};
        vecs[4]  = '{0, 1, 0, 1, 16'h0000, 16'h5959, 16'h0000, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 16'h1000, 16'h9999, 16'h1000, 0, 0};
        vecs[6]  = '{0, 1, 1, 0, 16'h0000, 16'h9999, 16'h0999, 0, 0};
        vecs[7]  = '{1, 0, 0, 0, 16'h0000, 16'h9999, 16'h0000, 0, 0};
        if (AUTOSTOP) vecs[8] = '{0, 1, 1, 0, 16'h0000, 16'h9999, 16'h0000, 0, 1};
        else          vecs[8] = '{0, 1, 1, 0, 16'h0000, 16'h9999, 16'h9999, 1, 0};
        vecs[9]  = '{1, 0, 1, 1, 16'h4321, 16'h9999, 16'h4321, 0, 0};
        vecs[10] = '{0, 0, 1, 1, 16'h0000, 16'h9999, 16'h4321, 0, 0};
        vecs[11] = '{0, 0, 1, 0, 16'h0000, 16'h9999, 16'h4321, 0, 0};
        vecs[12] = '{0, 1, 1, 0, 16'h0000, 16'h9999, 16'h4320, 0, 0};
        vecs[13] = '{0, 1, 1, 1, 16'h0000, 16'h9999, 16'h4321, 0, 0};
        vecs[14] = '{1, 0, 0, 1, 16'h000C, 16'h9999, 16'h000C, 0, 0};
        vecs[15] = '{0, 1, 1, 1, 16'h0000, 16'h9999, 16'h0010, 0, 0};
        vecs[16] = '{1, 0, 0, 0, 16'h000C, 16'h9999, 16'h000C, 0, 0};
        vecs[17] = '{0, 1, 1, 0, 16'h0000, 16'h9999, 16'h000B, 0, 0};
        vecs[18] = '{1, 0, 0, 1, 16'h9999, 16'hFFFF, 16'h9999, 0, 0};
        vecs[19] = '{0, 1, 1, 1, 16'h0000, 16'hFFFF, 16'h0000, 1, 0};
        if (AUTOSTOP) vecs[20] = '{0, 1, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 0, 1};
        else          vecs[20] = '{0, 1, 1, 0, 16'h0000, 16'hFFFF, 16'h9999, 1, 0};

        drive(0, 0, 0, 0, 1, 16'h0123, 16'h9999);
        edge_check("reset", 16'h0123, 0, 0);

        foreach (vecs[i]) begin
            drive(1, vecs[i].load, vecs[i].en, vecs[i].tick, vecs[i].up, vecs[i].init, vecs[i].limit);
            edge_check($sformatf("vec%0d", i), vecs[i].exp_val, vecs[i].exp_wrap, vecs[i].exp_done);
        end

        // Down through zero: auto-stop parks and sticks, otherwise borrow wraps.
        drive(1, 1, 0, 0, 0, 16'h0001, 16'h9999);
        edge_check("stop_load", 16'h0001, 0, 0);
        drive(1, 0, 1, 1, 0, 16'h0000, 16'h9999);
        edge_check("stop_t1", 16'h0000, 0, 0);
        if (AUTOSTOP) begin
            edge_check("stop_t2", 16'h0000, 0, 1);
            edge_check("stop_t3", 16'h0000, 0, 1);
        end else begin
            edge_check("stop_t2", 16'h9999, 1, 0);
            edge_check("stop_t3", 16'h9998, 0, 0);
        end
        drive(1, 1, 0, 0, 0, 16'h0001, 16'h9999);
        edge_check("stop_reload", 16'h0001, 0, 0);

        // Reset on the same edge as a wrapping tick.
        drive(1, 1, 0, 0, 1, 16'h9999, 16'h9999);
        edge_check("rmid_load", 16'h9999, 0, 0);
        drive(0, 0, 1, 1, 1, 16'h0042, 16'h9999);
        edge_check("rmid_rst", 16'h0042, 0, 0);
        drive(1, 0, 0, 0, 1, 16'h0042, 16'h9999);
        edge_check("rmid_after", 16'h0042, 0, 0);

        // Randomized run against the reference model.
        for (int i = 0; i < ND; i++) limit[i*4 +: 4] = 4'($urandom_range(0, 15));
        init_value = rand_valid(limit);
        rst_n = 0; load = 0; en = 0; tick = 0; up = 0;
        model_edge();
        @(posedge clk);
        #1;
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            load  = ($urandom_range(0, 15) == 0);
            en    = ($urandom_range(0, 3) != 0);
            tick  = $urandom_range(0, 1) == 1;
            up    = (c % 200) < 100 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            init_value = rand_valid(limit);
            model_edge();
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d value", c), 32'(value), 32'(m_val));
            check($sformatf("rnd%0d wrap", c), 32'(wrap), 32'(m_wrap));
            check($sformatf("rnd%0d done", c), 32'(done), 32'(m_done));
            check($sformatf("rnd%0d is_zero", c), 32'(is_zero), 32'(m_val == '0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of cascaded BCD digits (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1, the single global clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port en, input, 1, counter enable; when low, the value holds and tick is ignored.
REQ-005 The block SHALL have port tick, input, 1, one-count step strobe.
REQ-006 The block SHALL have port up, input, 1, count direction: 1 = up, 0 = down.
REQ-007 The block SHALL have port load, input, 1, synchronous load of init_value.
REQ-008 The block SHALL have port init_value, input, 4*NUM_DIGITS, reset/load value; digit 0 is in bits [3:0].
REQ-009 The block SHALL have port limit, input, 4*NUM_DIGITS, per-digit maximum value.
REQ-010 The block SHALL have port value, output, 4*NUM_DIGITS, registered counter value.
REQ-011 The block SHALL have port wrap, output, 1, registered one-cycle pulse on a full-counter wrap.
REQ-012 The block SHALL have port is_zero, output, 1, combinational flag: all digits = 0.
REQ-013 The block SHALL have port done, output, 1, registered auto-stop flag (see Configuration).

Function
REQ-014 The counter SHALL treat any limit digit above 9 as 9.
REQ-015 A step SHALL occur on an edge where en=1, tick=1 and load=0.
REQ-016 Digit 0 SHALL change on every step; digit i>0 SHALL change only when all lower digits are at limit (up) or at 0 (down) in the same cycle.
REQ-017 In up mode, a digit at or above its limit SHALL become 0; otherwise it SHALL increment by 1.
REQ-018 In down mode, a digit at 0 SHALL become its clamped limit; otherwise it SHALL decrement by 1.
REQ-019 The new value SHALL appear one clock after the step edge, with no combinational path from tick to value.
REQ-020 wrap SHALL be 1 for exactly the cycle following a step in which every digit wrapped, and 0 otherwise.
REQ-021 load SHALL have priority over tick and en: value <= init_value, wrap <= 0 and done <= 0.
REQ-022 A change of up between steps SHALL take effect on the next step, with no extra state.
REQ-023 Loaded digits above 9 SHALL be stored unchanged; the next step SHALL apply REQ-017/REQ-018 (up wraps to 0, down decrements).

Reset
REQ-024 When rst_n=0 at a clock edge, the block SHALL set value <= init_value, wrap <= 0 and done <= 0.
REQ-025 Reset SHALL take priority over load, tick and en, and SHALL abort any step in progress without a wrap pulse.

Configuration
REQ-026 With macro BCD_COUNTER_AUTOSTOP_EN defined, a down step from all-zero SHALL leave value at 0, set done to 1 and suppress wrap.
REQ-027 With BCD_COUNTER_AUTOSTOP_EN defined, done SHALL stay 1 (sticky) until reset or load, and further steps SHALL be ignored while done=1.
REQ-028 With BCD_COUNTER_AUTOSTOP_EN undefined, down counting SHALL wrap per REQ-018 and done SHALL be constant 0.

Structure
REQ-029 Shared package bcd_pkg SHALL hold BCD_W=4, BCD_ZERO=4'd0 and BCD_NINE=4'd9, plus the limit-clamp function.
REQ-030 The block SHALL instantiate NUM_DIGITS copies of sub-module bcd_digit.
REQ-031 bcd_digit SHALL provide: value register, step-in, up, limit, load, init, and a wrap-out to the next digit.
REQ-032 The top level SHALL hold the digit generate loop, wrap/done registers and the is_zero reduction.

Verification
REQ-033 Reset: NUM_DIGITS=4, init_value=16'h0123, rst_n low for 1 edge -> value=0123, wrap=0, done=0.
REQ-034 Minutes:seconds: limit=16'h5959, up=1, value=0059, one tick -> 0100; from 5959, one tick -> 0000 with wrap=1 for exactly 1 cycle.
REQ-035 Down borrow: limit=16'h9999, up=0, value=1000, one tick -> 0999; from 0000 with macro undefined -> 9999 and wrap=1.
REQ-036 Auto-stop: macro defined, value=0001, down, 3 ticks -> 0000, done=1 from the second tick on, wrap never 1; load -> done=0.
REQ-037 Priority: load=1, tick=1, en=0, init_value=4321 -> 4321; en=0 with tick pulses -> value unchanged.
REQ-038 Reset mid-count: rst_n=0 on the same edge as a wrapping tick -> value=init_value, wrap=0.
